// File: rtl/lcd_switch_display.sv
// lcd_switch_display: shows the current switch code as "SW:nn" on line 1 of
// an HD44780-style character LCD (8-bit bus, write only). Runs the power-on
// init once, then redraws whenever the code differs from what is on screen.
module lcd_switch_display #(
  parameter int CLK_HZ       = 50000000,
  parameter int INIT_WAIT_US = 15000,
  parameter int CMD_WAIT_US  = 40,
  parameter int CLR_WAIT_US  = 1640,
  parameter int EN_PULSE_CYC = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] code,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_on,
  output logic       busy,
  output logic       done
);

  localparam int CYC_PER_US = CLK_HZ / 1000000;
  localparam int INIT_CYC   = CYC_PER_US * INIT_WAIT_US;
  localparam int CMD_CYC    = CYC_PER_US * CMD_WAIT_US;
  localparam int CLR_CYC    = CYC_PER_US * CLR_WAIT_US;
  localparam int MAX_A      = (INIT_CYC > CLR_CYC) ? INIT_CYC : CLR_CYC;
  localparam int MAX_B      = (CMD_CYC > EN_PULSE_CYC) ? CMD_CYC : EN_PULSE_CYC;
  localparam int MAX_CYC    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW         = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYC - 1);
  localparam logic [CW-1:0] CMD_LAST  = CW'(CMD_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYC - 1);
  localparam logic [CW-1:0] EN_LAST   = CW'(EN_PULSE_CYC);

  typedef enum logic [2:0] {PWR_WAIT, INIT, LATCH, WRITE, FINISH, IDLE} state_t;
  typedef enum logic [1:0] {SETUP, PULSE, HOLD} sub_t;

  state_t        state_q;
  sub_t          sub_q;
  logic [2:0]    idx_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    snap_q, disp_q;
  logic [7:0]    data_q;
  logic          rs_q, en_q, busy_q, done_q;

  logic [7:0]    tens, ones, byte_sel;
  logic          rs_sel;
  logic [CW-1:0] hold_last;

  // Two ASCII digits for the latched code; out-of-range codes show "--".
  always_comb begin
    tens = 8'h2D;
    ones = 8'h2D;
    if (snap_q >= 5'd1 && snap_q <= 5'd9) begin
      tens = 8'h30;
      ones = 8'h30 + {3'b000, snap_q};
    end else if (snap_q >= 5'd10 && snap_q <= 5'd18) begin
      tens = 8'h31;
      ones = 8'h30 + {3'b000, snap_q} - 8'd10;
    end
  end

  // Byte to send for the current step of the init or redraw sequence.
  always_comb begin
    byte_sel = 8'h00;
    rs_sel   = 1'b0;
    if (state_q == INIT) begin
      case (idx_q)
        3'd0, 3'd1, 3'd2: byte_sel = 8'h38;
        3'd3:             byte_sel = 8'h0C;
        3'd4:             byte_sel = 8'h01;
        default:          byte_sel = 8'h06;
      endcase
    end else begin
      rs_sel = 1'b1;
      case (idx_q)
        3'd0: begin byte_sel = 8'h80; rs_sel = 1'b0; end
        3'd1: byte_sel = 8'h53;
        3'd2: byte_sel = 8'h57;
        3'd3: byte_sel = 8'h3A;
        3'd4: byte_sel = tens;
        default: byte_sel = ones;
      endcase
    end
  end

  // A clear-display command needs the long settle time; everything else the short one.
  always_comb hold_last = (data_q == 8'h01 && !rs_q) ? CLR_LAST : CMD_LAST;

  // Main sequencer: top-level phase plus SETUP/PULSE/HOLD byte-write sub-state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PWR_WAIT;
      sub_q   <= SETUP;
      idx_q   <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      disp_q  <= '0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        PWR_WAIT: begin
          if (cnt_q == INIT_LAST) begin
            cnt_q   <= '0;
            sub_q   <= SETUP;
            idx_q   <= '0;
            state_q <= INIT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        INIT, WRITE: begin
          case (sub_q)
            SETUP: begin
              data_q <= byte_sel;
              rs_q   <= rs_sel;
              en_q   <= 1'b0;
              cnt_q  <= '0;
              sub_q  <= PULSE;
            end
            PULSE: begin
              // en goes high the cycle after SETUP and stays EN_PULSE_CYC cycles.
              if (cnt_q == EN_LAST) begin
                en_q  <= 1'b0;
                cnt_q <= '0;
                sub_q <= HOLD;
              end else begin
                en_q  <= 1'b1;
                cnt_q <= cnt_q + CW'(1);
              end
            end
            HOLD: begin
              if (cnt_q == hold_last) begin
                cnt_q <= '0;
                sub_q <= SETUP;
                if (idx_q == 3'd5) begin
                  idx_q   <= '0;
                  state_q <= (state_q == INIT) ? LATCH : FINISH;
                end else begin
                  idx_q <= idx_q + 3'd1;
                end
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
            default: sub_q <= SETUP;
          endcase
        end
        LATCH: begin
          snap_q  <= code;
          idx_q   <= '0;
          sub_q   <= SETUP;
          state_q <= WRITE;
        end
        FINISH: begin
          disp_q  <= snap_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        IDLE: begin
          if (code != disp_q) begin
            busy_q  <= 1'b1;
            state_q <= LATCH;
          end
        end
        default: state_q <= PWR_WAIT;
      endcase
    end
  end

  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = en_q;
  assign lcd_on   = ~rst;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_lcd_switch_display.sv
// Bench for lcd_switch_display: captures every LCD write on the enable falling
// edge and compares against byte lists built from the display rules.
module tb_lcd_switch_display;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] code = 5'd0;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on, busy, done;

  always #5 clk = ~clk;

  lcd_switch_display #(
    .CLK_HZ(1000000), .INIT_WAIT_US(20), .CMD_WAIT_US(4),
    .CLR_WAIT_US(10), .EN_PULSE_CYC(2)
  ) dut (
    .clk(clk), .rst(rst), .code(code), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_on(lcd_on), .busy(busy), .done(done)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [8:0] wr_q[$];
  logic [8:0] exp_q[$];
  int hi_all[$], gap_all[$], req_all[$];
  int done_cnt = 0;
  int first_rise = -1;
  int disp_m = 0;

  // Monitor: records {rs,data} per write, enable-high widths, low gaps.
  initial begin
    bit prev_en, had_fall, last_clr;
    int hi, lo, cyc;
    prev_en = 0; had_fall = 0; last_clr = 0; hi = 0; lo = 0; cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_en = 0; had_fall = 0; hi = 0; lo = 0; cyc = 0; first_rise = -1;
      end else begin
        cyc++;
        if (lcd_en) begin
          if (!prev_en) begin
            if (had_fall) begin
              gap_all.push_back(lo);
              req_all.push_back(last_clr ? 10 : 4);
            end
            if (first_rise < 0) first_rise = cyc;
            hi = 0;
          end
          hi++;
        end else begin
          if (prev_en) begin
            wr_q.push_back({lcd_rs, lcd_data});
            hi_all.push_back(hi);
            last_clr = (lcd_data == 8'h01) && !lcd_rs;
            had_fall = 1;
            lo = 0;
          end
          lo++;
        end
        if (done) done_cnt++;
        prev_en = lcd_en;
      end
    end
  end

  // Reference: init command list.
  function automatic void exp_init();
    exp_q.push_back({1'b0, 8'h38}); exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h38}); exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01}); exp_q.push_back({1'b0, 8'h06});
  endfunction

  // Reference: one redraw of "SW:nn" for switch number c.
  function automatic void exp_update(input int c);
    logic [7:0] t, o;
    if (c >= 1 && c <= 18) begin
      t = 8'(48 + c / 10);
      o = 8'(48 + c % 10);
    end else begin
      t = "-";
      o = "-";
    end
    exp_q.push_back({1'b0, 8'h80});
    exp_q.push_back({1'b1, "S"}); exp_q.push_back({1'b1, "W"});
    exp_q.push_back({1'b1, ":"});
    exp_q.push_back({1'b1, t}); exp_q.push_back({1'b1, o});
  endfunction

  task automatic clear_obs();
    wr_q.delete(); exp_q.delete(); done_cnt = 0;
  endtask

  task automatic set_code(input int v);
    @(posedge clk); #1 code = 5'(v);
  endtask

  // Waits until busy has stayed low for 30 cycles; ok=0 on budget expiry.
  task automatic wait_quiet(input int budget, output bit ok);
    int q;
    q = 0; ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) q++; else q = 0;
      if (q >= 30) begin ok = 1; break; end
    end
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wr_q.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1; code = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, busy, done} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: data=%h rs=%b rw=%b en=%b on=%b busy=%b done=%b, want 00 0 0 0 0 1 0",
               lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, busy, done);
    end
  endtask

  task automatic test_init();
    bit ok;
    clear_obs();
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    n_chk++;
    if (lcd_on !== 1'b1) begin n_fail++; $display("FAIL lcd_on_after_release: got %b want 1", lcd_on); end
    wait_quiet(3000, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL init_timeout: busy still %b want 0", busy); end
    exp_init(); exp_update(0); disp_m = 0;
    n_chk++;
    if (wr_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL init_count: got %0d want %0d", wr_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_chk++;
      if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL init_byte[%0d]: got %h want %h", i, wr_q[i], exp_q[i]); end
    end
    n_chk++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL init_done: got %0d pulses want 1", done_cnt); end
    n_chk++;
    if (first_rise < 20) begin n_fail++; $display("FAIL init_first_rise: got cycle %0d want >= 20", first_rise); end
  endtask

  // Fixed codes plus randomized ones; each compared to the model redraw.
  task automatic test_codes(input int n_rand);
    bit ok;
    int c, nw;
    for (int k = 0; k < 3 + n_rand; k++) begin
      c = (k == 0) ? 7 : (k == 1) ? 18 : (k == 2) ? 19 : int'($urandom_range(0, 31));
      clear_obs();
      set_code(c);
      wait_quiet(2000, ok);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL code%0d_timeout: busy %b want 0", c, busy); end
      if (c != disp_m) exp_update(c);
      n_chk++;
      if (wr_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL code%0d_count: got %0d want %0d", c, wr_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
        n_chk++;
        if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL code%0d_byte[%0d]: got %h want %h", c, i, wr_q[i], exp_q[i]); end
      end
      n_chk++;
      if (done_cnt !== ((c != disp_m) ? 1 : 0)) begin n_fail++; $display("FAIL code%0d_done: got %0d", c, done_cnt); end
      disp_m = c;
      nw = wr_q.size();
      repeat (50) @(negedge clk);
      n_chk++;
      if (wr_q.size() !== nw) begin n_fail++; $display("FAIL code%0d_held: got %0d writes want %0d", c, wr_q.size(), nw); end
    end
  endtask

  task automatic test_midchange();
    bit ok, ok2;
    set_code(0);
    wait_quiet(2000, ok);
    disp_m = 0;
    clear_obs();
    set_code(3);
    wait_writes(2, 1000, ok);
    set_code(12);
    wait_quiet(3000, ok2);
    n_chk++;
    if (!(ok && ok2)) begin n_fail++; $display("FAIL midchange_timeout: got %b%b want 11", ok, ok2); end
    exp_update(3); exp_update(12); disp_m = 12;
    n_chk++;
    if (wr_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL midchange_count: got %0d want %0d", wr_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_chk++;
      if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midchange_byte[%0d]: got %h want %h", i, wr_q[i], exp_q[i]); end
    end
    n_chk++;
    if (done_cnt !== 2) begin n_fail++; $display("FAIL midchange_done: got %0d want 2", done_cnt); end
  endtask

  // 3 -> 5 -> 3 while the "03" redraw is running: only one redraw.
  task automatic test_revert();
    bit ok, ok2, ok3;
    clear_obs();
    set_code(3);
    wait_writes(1, 1000, ok);
    set_code(5);
    wait_writes(3, 1000, ok2);
    set_code(3);
    wait_quiet(3000, ok3);
    n_chk++;
    if (!(ok && ok2 && ok3)) begin n_fail++; $display("FAIL revert_timeout: got %b%b%b want 111", ok, ok2, ok3); end
    exp_update(3); disp_m = 3;
    n_chk++;
    if (wr_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL revert_count: got %0d want %0d", wr_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_chk++;
      if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL revert_byte[%0d]: got %h want %h", i, wr_q[i], exp_q[i]); end
    end
    n_chk++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL revert_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_midwrite();
    bit ok, seen;
    set_code(9);
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (lcd_en) begin seen = 1; break; end
    end
    n_chk++;
    if (!seen) begin n_fail++; $display("FAIL rst_mid_no_en: lcd_en never high"); end
    #1 rst = 1;
    #1;
    n_chk++;
    if ({lcd_en, busy, done, lcd_on} !== 4'b0100) begin
      n_fail++;
      $display("FAIL rst_mid_async: en=%b busy=%b done=%b on=%b want 0 1 0 0", lcd_en, busy, done, lcd_on);
    end
    repeat (3) @(negedge clk);
    clear_obs();
    @(posedge clk); #1 rst = 0;
    wait_quiet(3000, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL rst_mid_timeout: busy %b want 0", busy); end
    exp_init(); exp_update(9); disp_m = 9;
    n_chk++;
    if (wr_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rst_mid_count: got %0d want %0d", wr_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_chk++;
      if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rst_mid_byte[%0d]: got %h want %h", i, wr_q[i], exp_q[i]); end
    end
    n_chk++;
    if (first_rise < 20) begin n_fail++; $display("FAIL rst_mid_first_rise: got %0d want >= 20", first_rise); end
  endtask

  // Strobe widths and inter-write gaps across the whole run.
  task automatic test_timing();
    for (int i = 0; i < hi_all.size(); i++) begin
      n_chk++;
      if (hi_all[i] !== 2) begin n_fail++; $display("FAIL en_width[%0d]: got %0d want 2", i, hi_all[i]); end
    end
    for (int i = 0; i < gap_all.size(); i++) begin
      n_chk++;
      if (gap_all[i] < req_all[i]) begin n_fail++; $display("FAIL en_gap[%0d]: got %0d want >= %0d", i, gap_all[i], req_all[i]); end
    end
    n_chk++;
    if (lcd_rw !== 1'b0) begin n_fail++; $display("FAIL rw_const: got %b want 0", lcd_rw); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_codes(6);
    test_midchange();
    test_revert();
    test_reset_midwrite();
    test_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
